// File: rtl/ann_pkg.sv
// Shared types and constants for the neural-network datapath blocks.
// Includes the saturating bias adder used by the output stage.
package ann_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ACT_ID    = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RSVD  = 2'd3
  } act_e;

  localparam data_t DATA_MAX = 32'sh7FFF_FFFF;
  localparam data_t DATA_MIN = 32'sh8000_0000;

  // Contents of the first pipeline stage: biased sum plus what S2 needs.
  typedef struct packed {
    data_t sum;
    logic  sat;
    act_e  act;
  } s1_t;

  // Contents of the output stage.
  typedef struct packed {
    data_t value;
    logic  sat;
  } s2_t;

  // Adds in 33 bits; a disagreement between the top two bits means the
  // true sum is outside the 32-bit range and is clamped toward its sign.
  function automatic s1_t sat_add(input data_t a, input data_t b, input act_e act);
    s1_t               r;
    logic [DATA_W:0]   wide;
    wide  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    r.act = act;
    if (wide[DATA_W] != wide[DATA_W-1]) begin
      r.sat = 1'b1;
      r.sum = wide[DATA_W] ? DATA_MIN : DATA_MAX;
    end else begin
      r.sat = 1'b0;
      r.sum = data_t'(wide[DATA_W-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational activation: identity, ReLU, or leaky ReLU with a
// power-of-two negative slope. The reserved select behaves as identity.
module act_unit
  import ann_pkg::*;
#(
  parameter int LEAK_SHIFT = 3
) (
  input  data_t value,
  input  act_e  act_sel,
  output data_t result
);

  always_comb begin
    result = value;
    if (value[DATA_W-1]) begin
      case (act_sel)
        ACT_RELU:  result = '0;
        // Arithmetic shift floors toward minus infinity, so -1 stays -1.
        ACT_LEAKY: result = value >>> LEAK_SHIFT;
        default:   result = value;
      endcase
    end
  end

endmodule

// File: rtl/neuron_output_stage.sv
// Bias-add and activation output stage: two-stage valid/ready pipeline
// with per-layer neuron counting and a layer-complete pulse.
module neuron_output_stage
  import ann_pkg::*;
#(
  parameter int NEURONS    = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] bias,
  input  logic [1:0]  act_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sat,
  output logic        out_last,
  output logic        layer_done
);

  localparam logic [15:0] LAST_IDX = 16'(NEURONS - 1);

  logic        s1_valid_q, s1_valid_d;
  s1_t         s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  s2_t         s2_q, s2_d;
  logic [15:0] cnt_q, cnt_d;
  logic        layer_done_q, layer_done_d;

  logic  s2_free;
  logic  s1_adv;
  logic  in_hs;
  logic  out_hs;
  logic  is_last;
  data_t act_value;

  // A stage may load when its successor is empty or draining this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s2_valid_q && out_ready;
  assign is_last  = (cnt_q == LAST_IDX);

  act_unit #(
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_act (
    .value   (s1_q.sum),
    .act_sel (s1_q.act),
    .result  (act_value)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_d         = s1_q;
    s2_valid_d   = s2_valid_q;
    s2_d         = s2_q;
    cnt_d        = cnt_q;
    layer_done_d = 1'b0;

    if (clear) begin
      // Flush dominates any handshake occurring in the same cycle.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (in_hs) begin
        s1_d       = sat_add(data_t'(in_data), data_t'(bias), act_e'(act_sel));
        s1_valid_d = 1'b1;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end

      if (s1_adv) begin
        s2_d.value = act_value;
        s2_d.sat   = s1_q.sat;
        s2_valid_d = 1'b1;
      end else if (out_hs) begin
        s2_valid_d = 1'b0;
      end

      if (out_hs) begin
        cnt_d        = is_last ? '0 : cnt_q + 16'd1;
        layer_done_d = is_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      cnt_q        <= '0;
      layer_done_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      cnt_q        <= cnt_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_q.value;
  assign out_sat    = s2_q.sat;
  assign out_last   = s2_valid_q && is_last;
  assign layer_done = layer_done_q;

endmodule

// File: tb/tb_neuron_output_stage.sv
// Bench for neuron_output_stage: a queue-based reference model checked every
// cycle, plus directed literal checks of saturation, activation and control.
module tb_neuron_output_stage;

  localparam int NEURONS = 4;
  localparam int LEAK    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [31:0] bias = '0;
  logic [1:0]  act_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_last;
  logic        layer_done;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  always #5 clk = ~clk;

  neuron_output_stage #(.NEURONS(NEURONS), .LEAK_SHIFT(LEAK)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bias(bias), .act_sel(act_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_last(out_last), .layer_done(layer_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, clamp to 32-bit range, then floor-divide
  // negatives by 2**LEAK for leaky, zero them for ReLU.
  function automatic void model(input logic [31:0] d, input logic [31:0] b,
                                input logic [1:0] s,
                                output logic [31:0] r, output logic sat);
    longint sum;
    longint m;
    sum = longint'($signed(d)) + longint'($signed(b));
    m   = 1;
    m   = m << LEAK;
    sat = 1'b0;
    if (sum > 64'sd2147483647) begin
      sum = 64'sd2147483647;
      sat = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      sum = -64'sd2147483648;
      sat = 1'b1;
    end
    if (sum < 0) begin
      if (s == 2'd1) sum = 0;
      else if (s == 2'd2) sum = -((-sum + m - 1) / m);
    end
    r = 32'(sum);
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        sat;
    int          acc;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          mcnt = 0;
  logic        exp_ld = 1'b0;
  logic        m_ev;
  logic [31:0] m_r;
  logic        m_s;
  logic        l_in_hs = 1'b0, l_out_hs = 1'b0, l_clr = 1'b0;
  logic [31:0] l_d, l_b;
  logic [1:0]  l_s;

  // Compare process: an item is visible one edge after the edge that took it.
  always @(negedge clk) begin
    if (rst) begin
      m_ev = (q.size() > 0) && (cyc - q[0].acc >= 1);
      chk("out_valid", out_valid, m_ev);
      if (m_ev) begin
        chk("out_data", out_data, q[0].d);
        chk("out_sat", out_sat, q[0].sat);
        chk("out_last", out_last, mcnt == NEURONS - 1);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      chk("layer_done", layer_done, exp_ld);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      l_in_hs  = in_valid && ((q.size() < 2) || out_ready);
      l_out_hs = m_ev && out_ready;
      l_clr    = clear;
      l_d      = in_data;
      l_b      = bias;
      l_s      = act_sel;
    end else begin
      l_in_hs  = 1'b0;
      l_out_hs = 1'b0;
      l_clr    = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cyc++;
      if (l_clr) begin
        q.delete();
        mcnt   = 0;
        exp_ld = 1'b0;
      end else begin
        exp_ld = 1'b0;
        if (l_out_hs) begin
          exp_ld = (mcnt == NEURONS - 1);
          mcnt   = (mcnt + 1) % NEURONS;
          void'(q.pop_front());
        end
        if (l_in_hs) begin
          model(l_d, l_b, l_s, m_r, m_s);
          q.push_back(item_t'{d: m_r, sat: m_s, acc: cyc});
        end
      end
    end
  end

  always @(negedge rst) begin
    q.delete();
    mcnt   = 0;
    exp_ld = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [31:0] d, input logic [31:0] b, input logic [1:0] s);
    int n;
    bit done;
    n    = 0;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    bias     = b;
    act_sel  = s;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    act_sel  = ~s;
    in_data  = $urandom;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never seen for data %h", d);
    end
  endtask

  task automatic send_check(input string name, input logic [31:0] d, input logic [31:0] b,
                            input logic [1:0] s, input logic [31:0] exp_d, input logic exp_s);
    send(d, b, s);
    @(negedge clk);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_sat"}, out_sat, exp_s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still expected", q.size());
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_sat"}, out_sat, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_layer_done"}, layer_done, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [31:0] sd [8] = '{32'd100, -32'sd50, 32'h7FFF_0000, 32'h8000_0010,
                          -32'sd9, 32'd0, -32'sd1000, 32'd77};
  logic [31:0] sb [8] = '{32'd1, 32'd10, 32'h0100_0000, -32'sd256,
                          32'd0, -32'sd8, 32'd200, -32'sd100};
  logic [1:0]  ss [8] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};

  initial begin
    #2;
    reset_literals("por");
    #21 rst = 1'b1;
    @(posedge clk);
    #1;

    // Positive overflow clamps; result appears two cycles after acceptance.
    send(32'h7FFF_FFF0, 32'h0000_0100, 2'd0);
    @(negedge clk);
    chk("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", out_valid, 1);
    chk("posclamp_data", out_data, 32'h7FFF_FFFF);
    chk("posclamp_sat", out_sat, 1);

    send_check("leaky_m20", -32'sd20, 32'd4, 2'd2, -32'sd2, 1'b0);
    send_check("relu_m20", -32'sd20, 32'd4, 2'd1, 32'd0, 1'b0);
    send_check("leaky_m1", -32'sd1, 32'd0, 2'd2, -32'sd1, 1'b0);
    send_check("rsvd_m7", -32'sd7, 32'd0, 2'd3, -32'sd7, 1'b0);
    send_check("negclamp", 32'h8000_0010, -32'sd256, 2'd0, 32'h8000_0000, 1'b1);

    // One full layer back to back.
    pulse_clear();
    send(32'd1, 32'd1, 2'd0);
    send(-32'sd5, 32'd0, 2'd1);
    send(-32'sd64, 32'd0, 2'd2);
    send(32'd9, 32'd0, 2'd2);
    @(negedge clk);
    @(negedge clk);
    chk("layer_last_flag", out_last, 1);
    chk("layer_last_data", out_data, 32'd9);
    @(negedge clk);
    chk("layer_done_pulse", layer_done, 1);
    @(negedge clk);
    chk("layer_done_single", layer_done, 0);

    // Random backpressure stream.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(sd[i], sb[i], ss[i]);
    ready_mode = 0;
    drain();

    // Clear with two in flight and the counter at 2.
    pulse_clear();
    send(32'd3, 32'd0, 2'd0);
    send(32'd4, 32'd0, 2'd0);
    drain();
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'd5, 32'd0, 2'd0);
    send(32'd6, 32'd0, 2'd0);
    @(negedge clk);
    chk("full_in_ready_low", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    ready_mode = 0;
    @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd999;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", out_valid, 0);
    chk("clear_out_last", out_last, 0);
    for (int i = 0; i < 4; i++) send(32'(i + 20), 32'd0, 2'd0);
    drain();

    // Asynchronous reset mid-stream.
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'd1000, 32'd5, 2'd0);
    send(-32'sd77, 32'd0, 2'd0);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    reset_literals("midrst");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(32'(i * 3), -32'sd4, 2'd1);
    drain();

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/neuron_output_stage.md
NEURON_OUTPUT_STAGE -- requirements
Module: neuron_output_stage

Interface
REQ-001 Parameter NEURONS, default 4, number of neurons per layer (results per layer); legal range 1..65535.
REQ-002 Parameter LEAK_SHIFT, default 3, right-shift amount for leaky-ReLU negative slope; legal range 0..31.
REQ-003 Port clk  input  1  single clock; all state on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port clear  input  1  synchronous flush of pipeline and neuron counter.
REQ-006 Port in_valid  input  1  in_data/bias/act_sel valid (from dot_product result).
REQ-007 Port in_ready  output  1  stage accepts input this cycle.
REQ-008 Port in_data  input  32  signed dot-product result.
REQ-009 Port bias  input  32  signed bias for this neuron.
REQ-010 Port act_sel  input  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 reserved (treated as identity).
REQ-011 Port out_valid  output  1  out_data valid.
REQ-012 Port out_ready  input  1  consumer accepts output.
REQ-013 Port out_data  output  32  signed activated neuron value.
REQ-014 Port out_sat  output  1  bias addition saturated for this result.
REQ-015 Port out_last  output  1  current output is neuron NEURONS-1 of the layer.
REQ-016 Port layer_done  output  1  one-cycle pulse after last neuron of a layer is handed off.

Function
REQ-017 Input handshake: transfer when in_valid && in_ready; output handshake: out_valid && out_ready.
REQ-018 Two-stage pipeline: S1 registers saturated in_data+bias, sat flag, act_sel; S2 registers activated value, sat flag.
REQ-019 Latency: result of an input accepted in cycle N presents out_valid in cycle N+2 absent backpressure.
REQ-020 Throughput: one result per cycle while out_ready held high; no bubbles inserted.
REQ-021 Each stage advances when downstream stage is empty or is handing off the same cycle; in_ready = S1 empty or S1 advancing.
REQ-022 Backpressure: with out_ready low, S2 holds out_data/out_sat/out_last stable; at most 2 results in flight; no loss, no duplication.
REQ-023 Addition: 33-bit signed sum; above 0x7FFFFFFF clamps to 0x7FFFFFFF, below 0x80000000 clamps to 0x80000000, out_sat=1; else out_sat=0.
REQ-024 ReLU: negative -> 0; non-negative unchanged.
REQ-025 Leaky ReLU: negative -> arithmetic shift right by LEAK_SHIFT (floor, so -1 stays -1); non-negative unchanged.
REQ-026 act_sel sampled with its data at input handshake; changes afterward do not affect in-flight results.
REQ-027 Neuron counter (16 bit) increments on each output handshake; wraps to 0 after NEURONS-1.
REQ-028 out_last = out_valid && counter == NEURONS-1; with NEURONS=1 every output is last.
REQ-029 layer_done asserted exactly the cycle after the handshake of an out_last result, for one cycle.
REQ-030 clear: both stages emptied, counter to 0, layer_done low next cycle; clear wins over a simultaneous input handshake (input dropped) and over output handshake (counter still 0).
REQ-031 No in_ready-to-in_valid or out_valid-to-out_ready combinational dependency required of the peers; in_ready may depend combinationally on out_ready.

Reset
REQ-032 rst low: out_valid=0, out_data=0, out_sat=0, out_last=0, layer_done=0, counter=0, both stages empty, immediately and asynchronously.
REQ-033 in_ready = 1 while and after reset (pipeline empty).
REQ-034 Reset mid-operation discards all in-flight results; first result after release is neuron 0.

Structure
REQ-035 Shared package ann_pkg holds: data_t (signed 32-bit), act_e enum (ACT_ID, ACT_RELU, ACT_LEAKY), DATA_MAX/DATA_MIN constants.
REQ-036 One combinational sub-module act_unit (value, act_sel, LEAK_SHIFT -> activated value) instantiated in S2 path.

Verification
REQ-037 in_data=0x7FFFFFF0, bias=0x100, act_sel=0 -> out_data=0x7FFFFFFF, out_sat=1, two cycles after accept.
REQ-038 in_data=-20, bias=4, act_sel=2, LEAK_SHIFT=3 -> out_data=-2; act_sel=1 -> 0; in_data=-1, bias=0, leaky -> -1.
REQ-039 Four back-to-back inputs, out_ready=1, NEURONS=4 -> four consecutive outputs, out_last on 4th, layer_done one cycle later, counter back to 0.
REQ-040 Stream of 8 inputs with out_ready toggled randomly -> 8 outputs in order, values stable while stalled, in_ready low when both stages full.
REQ-041 clear asserted with 2 results in flight and counter=2 -> out_valid=0 next cycle, counter=0, next output is neuron 0.
REQ-042 rst pulsed low mid-stream -> outputs zero asynchronously, in_ready=1, subsequent layer counts from 0.
